retire_serializer: RTL and testbench
====================================

# retire_serializer

Consumes the dual-slot retirement stream produced by the superscalar core (slots a and b, with slot a older) and buffers each retired instruction in a FIFO. It emits records one per cycle, in program order, on a valid/ready stream for the commit tracer and the co-simulation checker. The core cannot be back-pressured, so the block must absorb bursts of up to two retirements per cycle. Any loss is flagged and counted, never silent.

## Interface
- DEPTH, 16: FIFO entries; power of two, ≥4.
- DROP_W, 16: width of the drop counter.
- clk  in  1  core clock; all state is rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- retire_valid_a / retire_valid_b  in  1  slot retires this cycle.
- retire_pc_{a,b}, retire_inst_{a,b}  in  32  PC and instruction word.
- retire_reg_addr_{a,b}  in  5  destination register.
- retire_reg_data_{a,b}  in  32  writeback value.
- retire_mem_addr_{a,b}, retire_mem_data_{a,b}  in  32  memory address and data.
- retire_mem_wrt_{a,b}  in  1  store flag.
- out_valid  out  1  head record available.
- out_ready  in  1  consumer accepts the head record.
- out_pc, out_inst, out_reg_data, out_mem_addr, out_mem_data  out  32  head record fields.
- out_reg_addr  out  5; out_mem_wrt  out  1; out_slot  out  1  (0 = came from slot a, 1 = from slot b).
- count  out  $clog2(DEPTH)+1  occupancy.
- clear_overflow  in  1  clears the sticky flag.
- overflow  out  1  sticky; at least one record was dropped.
- drop_count  out  DROP_W  number of records dropped; saturates.

## Operation
- Push order each cycle: a first, then b. If only b is valid, b takes the first free slot.
- pop = out_valid && out_ready. A pop frees its slot in the same cycle: free = DEPTH − count + pop.
- Space for all valid slots: push them all.
- Both slots valid and free == 1: push a, drop b. Dropping only b keeps the stored records a program-order prefix.
- free == 0: drop every valid slot.
- On any drop:
  - overflow ← 1.
  - drop_count += records dropped (1 or 2), saturating at all-ones.
- clear_overflow clears overflow only; drop_count is cleared only by reset. If clear_overflow and a drop occur in the same cycle, the set wins.
- Records are stored unmodified, including rd = x0 and non-memory instructions.
- out_* data fields are driven to 0 whenever out_valid = 0.
- count_next = count + pushes − pop, where pushes ∈ {0,1,2}.
- Head and tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.

## Timing
- Reset values (asynchronous): pointers 0, count 0, out_valid 0, overflow 0, drop_count 0, all out_* 0. The storage array is not reset.
- Latency: a record pushed at the edge ending cycle N appears on out_* in cycle N+1, provided it is at the head.
- First-word fall-through: out_* shows the head entry combinationally from registered storage. No output depends combinationally on retire_* inputs.
- out_ready may be asserted while out_valid = 0; this has no effect.
- The consumer may hold out_ready low indefinitely. Records stay stable while out_valid && !out_ready.
- Full with pop and two pushes in the same cycle: free = 1, so a is accepted and b is dropped.
- reset_n asserted mid-stream: all buffered records are discarded immediately. After reset_n deasserts, out_valid stays 0 until the first push.

## Structure
- core_types_pkg gains:
  - retire_record_t (packed: pc, inst, reg_addr, reg_data, mem_addr, mem_data, mem_wrt, slot; 167 bits).
  - RETIRE_REC_W.
- Sub-module retire_fifo_2w1r holds the storage and pointer/count logic: two write ports (in-order), one read port, and a push-accept output.
- The top level forms records from the two slots and holds the push/drop decision, overflow flag, drop counter and output gating.

## Test plan
- Single stream: slot a only, PCs 0x100, 0x104, 0x108, out_ready = 1 → three records in order, each one cycle after its push, out_slot = 0.
- Dual retire: a = 0x200, b = 0x204 in one cycle; out_ready held 0 for 2 cycles, then 1 → records 0x200 then 0x204, count 2 → 1 → 0.
- Fill to DEPTH = 16 with out_ready = 0, then one dual retire → both dropped, drop_count = 2, overflow = 1, count stays 16.
- count = 15, dual retire with out_ready = 0 → a stored, b dropped, drop_count += 1. The same cycle with out_ready = 1 and count = 16 → a stored, b dropped, count = 16.
- clear_overflow pulse with no drop → overflow = 0 and drop_count unchanged. clear_overflow coincident with a drop → overflow stays 1.
- reset_n pulsed low mid-burst with 5 records buffered → out_valid = 0, count = 0, drop_count = 0 at once. The next push appears at the output one cycle later.

Source files
------------

// File: rtl/core_types_pkg.sv
// core_types_pkg: shared types for the core's retirement/trace path.
//   retire_record_t : one retired instruction as seen by the commit tracer
//                     (167 bits, pc in the MSBs, slot in the LSB).
//   RETIRE_REC_W    : width of retire_record_t.
//   make_record     : helper that packs the per-slot retire fields.
package core_types_pkg;

    localparam int RETIRE_REC_W = 167;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  reg_addr;
        logic [31:0] reg_data;
        logic [31:0] mem_addr;
        logic [31:0] mem_data;
        logic        mem_wrt;
        logic        slot;      // 0 = retired on slot a, 1 = slot b
    } retire_record_t;

    function automatic retire_record_t make_record(
        input logic [31:0] pc,
        input logic [31:0] inst,
        input logic [4:0]  reg_addr,
        input logic [31:0] reg_data,
        input logic [31:0] mem_addr,
        input logic [31:0] mem_data,
        input logic        mem_wrt,
        input logic        slot
    );
        retire_record_t r;
        r.pc       = pc;
        r.inst     = inst;
        r.reg_addr = reg_addr;
        r.reg_data = reg_data;
        r.mem_addr = mem_addr;
        r.mem_data = mem_data;
        r.mem_wrt  = mem_wrt;
        r.slot     = slot;
        return r;
    endfunction

endpackage

// File: rtl/retire_fifo_2w1r.sv
// retire_fifo_2w1r: FIFO with two in-order write ports and one read port.
//   clk, reset_n          : clock, asynchronous active-low reset
//   wr_en_0 / wr_data_0   : first write of the cycle, lands at the tail
//   wr_en_1 / wr_data_1   : second write, lands at tail+1; only legal with wr_en_0
//   rd_en                 : consume the head entry (ignored when empty)
//   rd_data               : head entry, fall-through from storage
//   count                 : occupancy, 0..DEPTH
//   accept                : writes that can be taken this cycle (0..2),
//                           counting the slot freed by a same-cycle read
module retire_fifo_2w1r #(
    parameter int DEPTH = 16,
    parameter int W     = 167
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en_0,
    input  logic [W-1:0]             wr_data_0,
    input  logic                     wr_en_1,
    input  logic [W-1:0]             wr_data_1,
    input  logic                     rd_en,
    output logic [W-1:0]             rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic [1:0]               accept
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic          pop;
    logic [CW-1:0] free;
    logic [1:0]    n_push;

    assign pop     = rd_en && (count != '0);
    // A read this cycle frees its slot for a write in the same cycle.
    assign free    = CW'(DEPTH) - count + CW'(pop);
    assign accept  = (free >= CW'(2)) ? 2'd2 : free[1:0];
    assign n_push  = {1'b0, wr_en_0} + {1'b0, wr_en_1};
    assign rd_data = mem[head];

    // Storage is deliberately not reset; the top gates the head when empty.
    always_ff @(posedge clk) begin
        if (wr_en_0) mem[tail] <= wr_data_0;
        if (wr_en_1) mem[tail + AW'(1)] <= wr_data_1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (pop) head <= head + AW'(1);
            tail  <= tail + AW'(n_push);
            count <= count + CW'(n_push) - CW'(pop);
        end
    end

endmodule

// File: rtl/retire_serializer.sv
// retire_serializer: turns the dual-slot retirement stream into a single
// in-order record stream for the commit tracer / co-sim checker.
//   clk, reset_n                : clock, asynchronous active-low reset
//   retire_*_a / retire_*_b     : retire slots (a is older); cannot be stalled
//   out_valid/out_ready, out_*  : record stream, head of the buffer
//   count                       : buffered records
//   clear_overflow              : clears the sticky overflow flag
//   overflow                    : sticky, some record has been dropped
//   drop_count                  : saturating number of dropped records
//
// Output handshake: a record transfers on every rising edge where
// out_valid && out_ready. out_valid and out_* come from registered state only,
// stay stable while out_valid && !out_ready, and out_ready with out_valid low
// is ignored.
module retire_serializer
    import core_types_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DROP_W = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   retire_valid_a,
    input  logic [31:0]            retire_pc_a,
    input  logic [31:0]            retire_inst_a,
    input  logic [4:0]             retire_reg_addr_a,
    input  logic [31:0]            retire_reg_data_a,
    input  logic [31:0]            retire_mem_addr_a,
    input  logic [31:0]            retire_mem_data_a,
    input  logic                   retire_mem_wrt_a,
    input  logic                   retire_valid_b,
    input  logic [31:0]            retire_pc_b,
    input  logic [31:0]            retire_inst_b,
    input  logic [4:0]             retire_reg_addr_b,
    input  logic [31:0]            retire_reg_data_b,
    input  logic [31:0]            retire_mem_addr_b,
    input  logic [31:0]            retire_mem_data_b,
    input  logic                   retire_mem_wrt_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_pc,
    output logic [31:0]            out_inst,
    output logic [4:0]             out_reg_addr,
    output logic [31:0]            out_reg_data,
    output logic [31:0]            out_mem_addr,
    output logic [31:0]            out_mem_data,
    output logic                   out_mem_wrt,
    output logic                   out_slot,
    output logic [$clog2(DEPTH):0] count,
    input  logic                   clear_overflow,
    output logic                   overflow,
    output logic [DROP_W-1:0]      drop_count
);

    localparam int SW = DROP_W + 1;

    retire_record_t        rec_a;
    retire_record_t        rec_b;
    retire_record_t        first_rec;
    retire_record_t        head_rec;
    retire_record_t        shown_rec;
    logic [RETIRE_REC_W-1:0] head_bits;
    logic [1:0]            accept;
    logic [1:0]            n_valid;
    logic [1:0]            n_push;
    logic [1:0]            n_drop;
    logic                  pop;
    logic [SW-1:0]         drop_sum;

    assign rec_a = make_record(retire_pc_a, retire_inst_a, retire_reg_addr_a,
                               retire_reg_data_a, retire_mem_addr_a,
                               retire_mem_data_a, retire_mem_wrt_a, 1'b0);
    assign rec_b = make_record(retire_pc_b, retire_inst_b, retire_reg_addr_b,
                               retire_reg_data_b, retire_mem_addr_b,
                               retire_mem_data_b, retire_mem_wrt_b, 1'b1);

    // Compact the valid slots so the oldest valid record uses write port 0.
    // With room for only one of two, a is kept and b dropped, so the buffer
    // always holds a program-order prefix of what retired.
    assign first_rec = retire_valid_a ? rec_a : rec_b;
    assign n_valid   = {1'b0, retire_valid_a} + {1'b0, retire_valid_b};
    assign n_push    = (n_valid < accept) ? n_valid : accept;
    assign n_drop    = n_valid - n_push;

    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;

    retire_fifo_2w1r #(
        .DEPTH (DEPTH),
        .W     (RETIRE_REC_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en_0   (n_push != 2'd0),
        .wr_data_0 (first_rec),
        .wr_en_1   (n_push == 2'd2),
        .wr_data_1 (rec_b),
        .rd_en     (pop),
        .rd_data   (head_bits),
        .count     (count),
        .accept    (accept)
    );

    assign head_rec  = retire_record_t'(head_bits);
    // Storage is unreset, so the head is masked whenever nothing is buffered.
    assign shown_rec = out_valid ? head_rec : '0;

    assign out_pc       = shown_rec.pc;
    assign out_inst     = shown_rec.inst;
    assign out_reg_addr = shown_rec.reg_addr;
    assign out_reg_data = shown_rec.reg_data;
    assign out_mem_addr = shown_rec.mem_addr;
    assign out_mem_data = shown_rec.mem_data;
    assign out_mem_wrt  = shown_rec.mem_wrt;
    assign out_slot     = shown_rec.slot;

    assign drop_sum = {1'b0, drop_count} + SW'(n_drop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            // A drop in the same cycle as clear_overflow keeps the flag set.
            if (n_drop != 2'd0) begin
                overflow   <= 1'b1;
                drop_count <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
            end else if (clear_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_retire_serializer.sv
module tb_retire_serializer;
  import core_types_pkg::*;

  localparam int DEPTH  = 16;
  localparam int DROP_W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        retire_valid_a = 1'b0, retire_valid_b = 1'b0;
  logic [31:0] retire_pc_a = '0, retire_inst_a = '0, retire_reg_data_a = '0;
  logic [31:0] retire_mem_addr_a = '0, retire_mem_data_a = '0;
  logic [4:0]  retire_reg_addr_a = '0;
  logic        retire_mem_wrt_a = 1'b0;
  logic [31:0] retire_pc_b = '0, retire_inst_b = '0, retire_reg_data_b = '0;
  logic [31:0] retire_mem_addr_b = '0, retire_mem_data_b = '0;
  logic [4:0]  retire_reg_addr_b = '0;
  logic        retire_mem_wrt_b = 1'b0;
  logic        out_ready = 1'b0;
  logic        clear_overflow = 1'b0;
  logic        out_valid;
  logic [31:0] out_pc, out_inst, out_reg_data, out_mem_addr, out_mem_data;
  logic [4:0]  out_reg_addr;
  logic        out_mem_wrt, out_slot;
  logic [4:0]  count;
  logic        overflow;
  logic [DROP_W-1:0] drop_count;

  retire_serializer #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .retire_valid_a(retire_valid_a), .retire_pc_a(retire_pc_a), .retire_inst_a(retire_inst_a),
    .retire_reg_addr_a(retire_reg_addr_a), .retire_reg_data_a(retire_reg_data_a),
    .retire_mem_addr_a(retire_mem_addr_a), .retire_mem_data_a(retire_mem_data_a),
    .retire_mem_wrt_a(retire_mem_wrt_a),
    .retire_valid_b(retire_valid_b), .retire_pc_b(retire_pc_b), .retire_inst_b(retire_inst_b),
    .retire_reg_addr_b(retire_reg_addr_b), .retire_reg_data_b(retire_reg_data_b),
    .retire_mem_addr_b(retire_mem_addr_b), .retire_mem_data_b(retire_mem_data_b),
    .retire_mem_wrt_b(retire_mem_wrt_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_reg_addr(out_reg_addr),
    .out_reg_data(out_reg_data), .out_mem_addr(out_mem_addr), .out_mem_data(out_mem_data),
    .out_mem_wrt(out_mem_wrt), .out_slot(out_slot),
    .count(count), .clear_overflow(clear_overflow), .overflow(overflow),
    .drop_count(drop_count)
  );

  logic [RETIRE_REC_W-1:0] dut_rec;
  assign dut_rec = {out_pc, out_inst, out_reg_addr, out_reg_data,
                    out_mem_addr, out_mem_data, out_mem_wrt, out_slot};

  // ---------------- scoreboard / model state ----------------
  logic [RETIRE_REC_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int m_count = 0;
  logic m_ovf = 1'b0;
  logic [DROP_W-1:0] m_drop = '0;

  task automatic check(input string tag, input logic [RETIRE_REC_W-1:0] obs,
                       input logic [RETIRE_REC_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic retire_record_t rand_rec(input logic [31:0] pc, input logic slot);
    retire_record_t r;
    r.pc       = pc;
    r.inst     = $urandom;
    r.reg_addr = 5'($urandom_range(0, 31));
    r.reg_data = $urandom;
    r.mem_addr = $urandom;
    r.mem_data = $urandom;
    r.mem_wrt  = 1'($urandom_range(0, 1));
    r.slot     = slot;
    return r;
  endfunction

  // ---------------- driver: one clock cycle ----------------
  // Called at posedge+1: drives inputs for the coming edge, checks the head,
  // updates the model, then checks registered state after the edge.
  task automatic cyc(input logic va, input logic vb, input logic [31:0] pca,
                     input logic [31:0] pcb, input logic rdy, input logic clr);
    retire_record_t ra, rb;
    int nv, free, np, nd, sum;
    logic pop;
    ra = rand_rec(pca, 1'b0);
    rb = rand_rec(pcb, 1'b1);
    retire_valid_a = va; retire_pc_a = ra.pc; retire_inst_a = ra.inst;
    retire_reg_addr_a = ra.reg_addr; retire_reg_data_a = ra.reg_data;
    retire_mem_addr_a = ra.mem_addr; retire_mem_data_a = ra.mem_data;
    retire_mem_wrt_a = ra.mem_wrt;
    retire_valid_b = vb; retire_pc_b = rb.pc; retire_inst_b = rb.inst;
    retire_reg_addr_b = rb.reg_addr; retire_reg_data_b = rb.reg_data;
    retire_mem_addr_b = rb.mem_addr; retire_mem_data_b = rb.mem_data;
    retire_mem_wrt_b = rb.mem_wrt;
    out_ready = rdy;
    clear_overflow = clr;
    #1;
    check("out_valid", RETIRE_REC_W'(out_valid), RETIRE_REC_W'(m_count != 0));
    pop = rdy && (m_count != 0);
    if (m_count != 0) begin
      check(pop ? "pop_rec" : "held_rec", dut_rec, exp_q[0]);
      if (pop) void'(exp_q.pop_front());
    end else begin
      check("idle_zero", dut_rec, '0);
    end
    free = DEPTH - m_count + (pop ? 1 : 0);
    nv = int'(va) + int'(vb);
    np = (nv < free) ? nv : free;
    nd = nv - np;
    if (np >= 1) exp_q.push_back(va ? ra : rb);
    if (np == 2) exp_q.push_back(rb);
    m_count = m_count + np - (pop ? 1 : 0);
    if (nd > 0) begin
      m_ovf = 1'b1;
      sum = int'(m_drop) + nd;
      m_drop = (sum > 65535) ? 16'hffff : 16'(sum);
    end else if (clr) begin
      m_ovf = 1'b0;
    end
    @(posedge clk); #1;
    check("count", RETIRE_REC_W'(count), RETIRE_REC_W'(m_count));
    check("overflow", RETIRE_REC_W'(overflow), RETIRE_REC_W'(m_ovf));
    check("drop_count", RETIRE_REC_W'(drop_count), RETIRE_REC_W'(m_drop));
  endtask

  task automatic idle(input logic rdy, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'h0, 32'h0, rdy, 1'b0);
  endtask

  // Asserts reset asynchronously at posedge+1 and checks it took effect at once.
  task automatic async_reset();
    retire_valid_a = 1'b0; retire_valid_b = 1'b0; out_ready = 1'b0; clear_overflow = 1'b0;
    reset_n = 1'b0;
    #1;
    check("rst_out_valid", RETIRE_REC_W'(out_valid), '0);
    check("rst_count", RETIRE_REC_W'(count), '0);
    check("rst_drop_count", RETIRE_REC_W'(drop_count), '0);
    check("rst_overflow", RETIRE_REC_W'(overflow), '0);
    check("rst_out_rec", dut_rec, '0);
    exp_q.delete();
    m_count = 0; m_ovf = 1'b0; m_drop = '0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_valid", RETIRE_REC_W'(out_valid), '0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    @(posedge clk); #1;
    async_reset();

    // single stream, slot a only
    cyc(1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 32'h104, 32'h0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 32'h108, 32'h0, 1'b1, 1'b0);
    idle(1'b1, 2);

    // dual retire, consumer stalls two cycles
    cyc(1'b1, 1'b1, 32'h200, 32'h204, 1'b0, 1'b0);
    check("dual_count2", RETIRE_REC_W'(count), RETIRE_REC_W'(2));
    idle(1'b0, 1);
    check("dual_held_pc", RETIRE_REC_W'(out_pc), RETIRE_REC_W'(32'h200));
    idle(1'b1, 1);
    check("dual_second_pc", RETIRE_REC_W'(out_pc), RETIRE_REC_W'(32'h204));
    check("dual_second_slot", RETIRE_REC_W'(out_slot), RETIRE_REC_W'(1));
    idle(1'b1, 1);

    // fill to DEPTH, then a dual retire is fully dropped
    for (int i = 0; i < DEPTH / 2; i++)
      cyc(1'b1, 1'b1, 32'h400 + 32'(i * 8), 32'h404 + 32'(i * 8), 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 32'h500, 32'h504, 1'b0, 1'b0);
    check("full_drop_count", RETIRE_REC_W'(drop_count), RETIRE_REC_W'(2));
    check("full_overflow", RETIRE_REC_W'(overflow), RETIRE_REC_W'(1));
    check("full_count", RETIRE_REC_W'(count), RETIRE_REC_W'(16));

    // count 15: a kept, b dropped
    idle(1'b1, 1);
    cyc(1'b1, 1'b1, 32'h600, 32'h604, 1'b0, 1'b0);
    check("c15_drop_count", RETIRE_REC_W'(drop_count), RETIRE_REC_W'(3));
    check("c15_count", RETIRE_REC_W'(count), RETIRE_REC_W'(16));
    // full with pop: freed slot takes a, b dropped
    cyc(1'b1, 1'b1, 32'h700, 32'h704, 1'b1, 1'b0);
    check("fullpop_drop_count", RETIRE_REC_W'(drop_count), RETIRE_REC_W'(4));
    check("fullpop_count", RETIRE_REC_W'(count), RETIRE_REC_W'(16));

    // clear_overflow alone, then coincident with a drop
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    check("clr_overflow", RETIRE_REC_W'(overflow), RETIRE_REC_W'(0));
    check("clr_keeps_drops", RETIRE_REC_W'(drop_count), RETIRE_REC_W'(4));
    cyc(1'b0, 1'b1, 32'h0, 32'h804, 1'b0, 1'b1);
    check("clr_vs_drop", RETIRE_REC_W'(overflow), RETIRE_REC_W'(1));

    // drain, then a random mix
    idle(1'b1, DEPTH);
    for (int i = 0; i < 80; i++)
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          32'h1000 + 32'(i * 8), 32'h1004 + 32'(i * 8),
          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0));
    idle(1'b1, DEPTH + 2);

    // reset mid-burst with 5 records buffered
    cyc(1'b1, 1'b1, 32'h2000, 32'h2004, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 32'h2008, 32'h200c, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 32'h2010, 32'h0, 1'b0, 1'b0);
    check("burst_count5", RETIRE_REC_W'(count), RETIRE_REC_W'(5));
    async_reset();
    cyc(1'b1, 1'b0, 32'h300, 32'h0, 1'b0, 1'b0);
    check("post_rst_push_valid", RETIRE_REC_W'(out_valid), RETIRE_REC_W'(1));
    check("post_rst_push_pc", RETIRE_REC_W'(out_pc), RETIRE_REC_W'(32'h300));
    idle(1'b1, 2);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
